sr_cmd_seq: RTL

Command sequencer that sits directly upstream of the SR flip-flop stage and drives its `s`/`r` inputs. It accepts single-cycle set/clear requests, queues them in a small FIFO and replays each as a one-cycle `s` or `r` pulse, with a programmable idle gap between pulses. It guarantees the downstream flip-flop never sees `s=r=1`. It also keeps a model of the flip-flop's expected `q` for checking.

---
 rtl/sr_cmd_pkg.sv | 18 +
 rtl/sr_cmd_fifo.sv | 54 +++++
 rtl/sr_cmd_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command sequencer: command encoding,
// FSM states and the width of the inter-pulse gap counter.
package sr_cmd_pkg;

  typedef enum logic {
    CMD_CLR = 1'b0,
    CMD_SET = 1'b1
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  localparam int GAP_W = 4;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous 1-bit-wide FIFO holding queued set/clear commands.
// Pushes when full and pops when empty are ignored.
module sr_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sr_cmd_seq.sv
// Queues single-cycle set/clear requests and replays them as one-cycle s/r
// pulses separated by GAP idle cycles; s and r are never high together.
module sr_cmd_seq
  import sr_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_req,
  input  logic                   clr_req,
  output logic                   s,
  output logic                   r,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   q_model,
  output logic                   conflict,
  output logic                   overflow
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] CNT_LAST = GAP_W'(1);

  state_t           state_q, state_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic             s_d, r_d, q_d;
  logic             one_req, full, empty, pop, take, fifo_dout;
  cmd_t             head;

  assign one_req = set_req ^ clr_req;
  assign head    = cmd_t'(fifo_dout);
  assign busy    = (state_q != IDLE) || !empty;

  sr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (one_req & ~full),
    .pop   (pop),
    .din   (set_req),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_model;
    s_d     = 1'b0;
    r_d     = 1'b0;
    pop     = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: take = !empty;
      ISSUE: begin
        q_d = s;
        if (GAP > 0) begin
          state_d = HOLD;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
          take    = !empty;
        end
      end
      // On gap expiry the next command issues on the same edge, giving GAP+1 spacing.
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          take    = !empty;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      pop     = 1'b1;
      s_d     = (head == CMD_SET);
      r_d     = (head == CMD_CLR);
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      q_model  <= 1'b0;
      conflict <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s        <= s_d;
      r        <= r_d;
      q_model  <= q_d;
      conflict <= set_req & clr_req;
      overflow <= one_req & full;
    end
  end

endmodule
